tetris_game_ctrl: RTL

//  Top-level sequencer for one falling piece on the 8x16 dot-matrix playfield.

---
 rtl/tetris_game_ctrl_pkg.sv | 46 ++++
 rtl/tetris_game_ctrl_btn_sync.sv | 21 ++
 rtl/tetris_game_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tetris_game_ctrl_pkg.sv
// Shared types and constants for the falling-piece sequencer.
// State encoding, piece ids, playfield size and LFSR helpers.
package tetris_game_ctrl_pkg;

  localparam int PF_ROWS = 16;
  localparam int SCORE_CAP = 9999;
  // x^8+x^6+x^5+x^4+1 as a mask over bits [7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_CHECK,
    ST_PLAY,
    ST_SETTLE,
    ST_LOCK,
    ST_SETTLE2,
    ST_SCAN,
    ST_GAME_OVER
  } state_t;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_J = 3'd2,
    PIECE_L = 3'd3,
    PIECE_S = 3'd4,
    PIECE_Z = 3'd5,
    PIECE_T = 3'd6
  } piece_t;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] v
  );
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [2:0] piece_id(
    input logic [7:0] v
  );
    if (v[2:0] == 3'd7)
      return {1'b0, v[4:3]};
    return v[2:0];
  endfunction

endpackage

// File: rtl/tetris_game_ctrl_btn_sync.sv
// Two-flop synchronizer for a raw button
// followed by a single-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sh <= '0;
    else
      sh <= {sh[1:0], btn};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/tetris_game_ctrl.sv
// Sequencer for one falling piece: turns buttons and gravity
// into one registered command pulse per settle window.
module tetris_game_ctrl
  import tetris_game_ctrl_pkg::*;
#(
  parameter int         ROWS      = PF_ROWS,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         SCORE_MAX = SCORE_CAP
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    left_btn,
  input  logic                    right_btn,
  input  logic                    start_btn,
  input  logic                    fall_tick,
  input  logic                    can_fall,
  input  logic                    spawn_blocked,
  input  logic [ROWS-1:0]         full_rows,
  output logic                    placed,
  output logic [2:0]              new_block_id,
  output logic                    right_button,
  output logic                    left_button,
  output logic                    drop_en,
  output logic                    lock_en,
  output logic                    clear_en,
  output logic [$clog2(ROWS)-1:0] clear_row,
  output logic [13:0]             score,
  output logic                    game_over
);

  localparam int CW = $clog2(ROWS);

  logic left_rise, right_rise, start_rise;

  btn_sync_edge u_left (
    .clk(CLK), .rst_n(rst_n),
    .btn(left_btn), .rise(left_rise)
  );
  btn_sync_edge u_right (
    .clk(CLK), .rst_n(rst_n),
    .btn(right_btn), .rise(right_rise)
  );
  btn_sync_edge u_start (
    .clk(CLK), .rst_n(rst_n),
    .btn(start_btn), .rise(start_rise)
  );

  state_t state, state_nx;
  logic [7:0] lfsr;
  logic pend_tick, pend_right, pend_left;
  logic clr_tick, clr_right, clr_left;
  logic placed_nx, right_nx, left_nx;
  logic drop_nx, lock_nx, clear_nx, go_nx;
  logic [2:0] id_nx;
  logic [CW-1:0] row_nx, bottom_row;
  logic [13:0] score_nx, score_inc;

  // Row ROWS-1 is the bottom, so the last hit wins.
  always_comb begin
    bottom_row = '0;
    for (int i = 0; i < ROWS; i++)
      if (full_rows[i])
        bottom_row = i[CW-1:0];
  end

  assign score_inc = (score < 14'(SCORE_MAX)) ? score + 14'd1 : score;

  always_comb begin
    state_nx  = state;
    placed_nx = 1'b0;
    right_nx  = 1'b0;
    left_nx   = 1'b0;
    drop_nx   = 1'b0;
    lock_nx   = 1'b0;
    clear_nx  = 1'b0;
    id_nx     = new_block_id;
    row_nx    = clear_row;
    score_nx  = score;
    go_nx     = game_over;
    clr_tick  = 1'b0;
    clr_right = 1'b0;
    clr_left  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_nx = ST_SPAWN;
          score_nx = '0;
        end
      end
      ST_SPAWN: begin
        placed_nx = 1'b1;
        id_nx     = piece_id(lfsr);
        state_nx  = ST_CHECK;
      end
      ST_CHECK: begin
        if (spawn_blocked) begin
          state_nx = ST_GAME_OVER;
          go_nx    = 1'b1;
        end else begin
          state_nx = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (pend_tick) begin
          clr_tick = 1'b1;
          if (can_fall) begin
            drop_nx  = 1'b1;
            state_nx = ST_SETTLE;
          end else begin
            state_nx = ST_LOCK;
          end
        end else if (pend_right) begin
          clr_right = 1'b1;
          right_nx  = 1'b1;
          state_nx  = ST_SETTLE;
        end else if (pend_left) begin
          clr_left = 1'b1;
          left_nx  = 1'b1;
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: state_nx = ST_PLAY;
      ST_LOCK: begin
        lock_nx  = 1'b1;
        state_nx = ST_SETTLE2;
      end
      ST_SETTLE2: state_nx = ST_SCAN;
      ST_SCAN: begin
        if (full_rows == '0) begin
          state_nx = ST_SPAWN;
        end else begin
          clear_nx = 1'b1;
          row_nx   = bottom_row;
          score_nx = score_inc;
          state_nx = ST_SETTLE2;
        end
      end
      ST_GAME_OVER: begin
        if (start_rise) begin
          go_nx    = 1'b0;
          score_nx = '0;
          state_nx = ST_SPAWN;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A fresh piece never inherits moves queued for the old one.
  logic spawn_entry;
  assign spawn_entry = (state_nx == ST_SPAWN);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      lfsr         <= LFSR_SEED;
      pend_tick    <= 1'b0;
      pend_right   <= 1'b0;
      pend_left    <= 1'b0;
      placed       <= 1'b0;
      new_block_id <= '0;
      right_button <= 1'b0;
      left_button  <= 1'b0;
      drop_en      <= 1'b0;
      lock_en      <= 1'b0;
      clear_en     <= 1'b0;
      clear_row    <= '0;
      score        <= '0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_nx;
      lfsr         <= lfsr_next(lfsr);
      pend_tick    <= !spawn_entry &&
                      (fall_tick || (pend_tick && !clr_tick));
      pend_right   <= !spawn_entry &&
                      (right_rise || (pend_right && !clr_right));
      pend_left    <= !spawn_entry &&
                      (left_rise || (pend_left && !clr_left));
      placed       <= placed_nx;
      new_block_id <= id_nx;
      right_button <= right_nx;
      left_button  <= left_nx;
      drop_en      <= drop_nx;
      lock_en      <= lock_nx;
      clear_en     <= clear_nx;
      clear_row    <= row_nx;
      score        <= score_nx;
      game_over    <= go_nx;
    end
  end

endmodule
